// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI master: register map, CTRL/STATUS
// bit positions, FSM state encoding and the STATUS packing helper.
package sd_spi_pkg;

    // Register select (CPU a[0])
    localparam logic REG_DATA = 1'b0;
    localparam logic REG_CTRL = 1'b1;

    // CTRL write bit positions
    localparam int BIT_SEL  = 0;
    localparam int BIT_SLOW = 7;

    // STATUS read bit positions
    localparam int BIT_BUSY = 7;
    localparam int BIT_OVR  = 6;
    localparam int BIT_DET  = 5;
    localparam int BIT_MISO = 4;
    localparam int STS_SLOW = 1;
    localparam int STS_SEL  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_e;

    // Assemble the STATUS byte: {busy, overrun, det, miso, 2'b0, slow, select}
    function automatic logic [7:0] pack_status(
        input logic busy,
        input logic ovr,
        input logic det,
        input logic miso,
        input logic slow,
        input logic sel
    );
        logic [7:0] s;
        s           = 8'h00;
        s[BIT_BUSY] = busy;
        s[BIT_OVR]  = ovr;
        s[BIT_DET]  = det;
        s[BIT_MISO] = miso;
        s[STS_SLOW] = slow;
        s[STS_SEL]  = sel;
        return s;
    endfunction

endpackage

// File: rtl/sd_spi_master_half_div.sv
// Loadable down-counter timing one sd_clk half-period. tc_o is high while
// the count sits at zero; the counter holds at zero until reloaded.
module spi_half_div #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    // Count register: load has priority over decrement, stops at zero
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/sd_spi_master.sv
// SPI master (mode 0) for the SD card on CPU ports F0/F1. A DATA write shifts
// a byte out MSB first while capturing MISO on each rising sd_clk; the CPU
// polls busy in STATUS and then reads the received byte from DATA.
module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter int SLOW_HALF = 12,
    parameter int FAST_HALF = 1
) (
    input  logic       phi,
    input  logic       reset,
    input  logic       addr,
    input  logic       wr_tick,
    input  logic       rd_tick,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       sd_clk,
    output logic       sd_mosi,
    output logic       sd_ssel_n,
    input  logic       sd_miso,
    input  logic       sd_det
);

    localparam int HMAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int DW   = (HMAX > 1) ? $clog2(HMAX) : 1;
    localparam logic [DW-1:0] SLOW_M1 = DW'(SLOW_HALF - 1);
    localparam logic [DW-1:0] FAST_M1 = DW'(FAST_HALF - 1);

    state_e        state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    rx_q;
    logic [DW-1:0] half_m1_q;
    logic          busy_q;
    logic          ovr_q;
    logic          slow_q;
    logic          sd_clk_q;
    logic          mosi_q;
    logic          ssel_n_q;

    logic          div_load_s;
    logic          div_dec_s;
    logic [DW-1:0] div_val_s;
    logic          div_tc_s;
    logic          start_s;

    assign start_s = wr_tick && (addr == REG_DATA);

    spi_half_div #(
        .W (DW)
    ) u_div (
        .clk_i      (phi),
        .reset_i    (reset),
        .load_i     (div_load_s),
        .load_val_i (div_val_s),
        .dec_i      (div_dec_s),
        .tc_o       (div_tc_s)
    );

    // Divider control: reload at transfer start and at each half-period end
    always_comb begin
        div_load_s = 1'b0;
        div_dec_s  = 1'b0;
        div_val_s  = half_m1_q;
        case (state_q)
            ST_IDLE: begin
                div_val_s  = slow_q ? SLOW_M1 : FAST_M1;
                div_load_s = start_s;
            end
            ST_LO: begin
                if (div_tc_s) begin
                    div_load_s = 1'b1;
                end else begin
                    div_dec_s = 1'b1;
                end
            end
            ST_HI: begin
                if (div_tc_s) begin
                    div_load_s = (bit_cnt_q != 3'd0);
                end else begin
                    div_dec_s = 1'b1;
                end
            end
            default: begin
                div_load_s = 1'b0;
                div_dec_s  = 1'b0;
            end
        endcase
    end

    // Transfer FSM, register file and sticky overrun flag
    always_ff @(posedge phi) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= 8'hFF;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'hFF;
            half_m1_q <= SLOW_M1;
            busy_q    <= 1'b0;
            ovr_q     <= 1'b0;
            slow_q    <= 1'b1;
            sd_clk_q  <= 1'b0;
            mosi_q    <= 1'b1;
            ssel_n_q  <= 1'b1;
        end else begin
            // A write always wins over a simultaneous read, so the clear is dropped
            if (wr_tick) begin
                if (busy_q) begin
                    ovr_q <= 1'b1;
                end
            end else if (rd_tick && (addr == REG_CTRL)) begin
                ovr_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (wr_tick) begin
                        if (addr == REG_DATA) begin
                            shift_q   <= din;
                            mosi_q    <= din[7];
                            bit_cnt_q <= 3'd7;
                            half_m1_q <= slow_q ? SLOW_M1 : FAST_M1;
                            busy_q    <= 1'b1;
                            state_q   <= ST_LO;
                        end else begin
                            ssel_n_q <= ~din[BIT_SEL];
                            slow_q   <= din[BIT_SLOW];
                        end
                    end
                end
                ST_LO: begin
                    // Rising sd_clk: sample MISO into the LSB
                    if (div_tc_s) begin
                        sd_clk_q <= 1'b1;
                        shift_q  <= {shift_q[6:0], sd_miso};
                        state_q  <= ST_HI;
                    end
                end
                ST_HI: begin
                    // Falling sd_clk: finish the byte or present the next bit
                    if (div_tc_s) begin
                        sd_clk_q <= 1'b0;
                        if (bit_cnt_q == 3'd0) begin
                            rx_q    <= shift_q;
                            busy_q  <= 1'b0;
                            mosi_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            mosi_q    <= shift_q[7];
                            bit_cnt_q <= bit_cnt_q - 3'd1;
                            state_q   <= ST_LO;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    sd_clk_q <= 1'b0;
                    mosi_q   <= 1'b1;
                end
            endcase
        end
    end

    // CPU read mux: STATUS on CTRL address, last completed byte on DATA
    always_comb begin
        if (addr == REG_CTRL) begin
            dout = pack_status(busy_q, ovr_q, sd_det, sd_miso, slow_q, ~ssel_n_q);
        end else begin
            dout = rx_q;
        end
    end

    assign sd_clk    = sd_clk_q;
    assign sd_mosi   = mosi_q;
    assign sd_ssel_n = ssel_n_q;

endmodule
